// File: rtl/cv32e40p_clk_en_ctrl.sv
// Core clock-enable controller: drains idle cycles before gating, re-enables on wake
// with a settling window, and counts gated cycles (saturating).
module cv32e40p_clk_en_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sleep_req_i,
  input  logic             busy_i,
  input  logic             wake_i,
  output logic             clk_en_o,
  output logic             core_sleep_o,
  output logic             wake_done_o,
  output logic [CNT_W-1:0] sleep_cnt_o
);

  localparam int unsigned MAX_CYCLES = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SLEEP,
    ST_WAKE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             core_sleep_q, core_sleep_d;
  logic             wake_done_q, wake_done_d;
  logic [CNT_W-1:0] sleep_cnt_q, sleep_cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its peers; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      clk_en_q     <= 1'b1;
      core_sleep_q <= 1'b0;
      wake_done_q  <= 1'b0;
      sleep_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_en_q     <= clk_en_d;
      core_sleep_q <= core_sleep_d;
      wake_done_q  <= wake_done_d;
      sleep_cnt_q  <= sleep_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    clk_en_d     = clk_en_q;
    core_sleep_d = core_sleep_q;
    wake_done_d  = 1'b0;
    sleep_cnt_d  = sleep_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (sleep_req_i && !wake_i) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end

      ST_DRAIN: begin
        // Abort wins over busy, and busy restarts the idle run from zero.
        if (wake_i || !sleep_req_i) begin
          state_d = ST_RUN;
        end else if (busy_i) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d      = ST_SLEEP;
          clk_en_d     = 1'b0;
          core_sleep_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SLEEP: begin
        if (sleep_cnt_q != {CNT_W{1'b1}}) begin
          sleep_cnt_d = sleep_cnt_q + 1'b1;
        end
        if (wake_i) begin
          state_d  = ST_WAKE;
          clk_en_d = 1'b1;
          cnt_d    = '0;
        end
      end

      ST_WAKE: begin
        // Wake always runs to completion, even if wake_i drops.
        if (cnt_q == WAKE_LAST) begin
          state_d      = ST_RUN;
          wake_done_d  = 1'b1;
          core_sleep_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign clk_en_o     = clk_en_q;
  assign core_sleep_o = core_sleep_q;
  assign wake_done_o  = wake_done_q;
  assign sleep_cnt_o  = sleep_cnt_q;

endmodule
